// File: rtl/airlock_sequencer.sv
// rtl/airlock_sequencer.sv - bidirectional airlock sequencer with its own seconds timer and breach fault
// Optional build macro AIRLOCK_AUTO_REPRESS_EN: DEPRESS auto-repressurises once the outer door has cycled.
module airlock_sequencer #(
  parameter int CLK_HZ  = 50000000,
  parameter int EXIT_S  = 5,
  parameter int EVAC_S  = 7,
  parameter int PRESS_S = 8,
  parameter int TIMER_W = 4
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               innerPort,
  input  logic               outerPort,
  input  logic               leaving,
  input  logic               evac,
  input  logic               pressurize,
  input  logic               faultClr,
  output logic               canIn,
  output logic               canOut,
  output logic [6:0]         display,
  output logic               fault,
  output logic               busy,
  output logic [TIMER_W-1:0] secsLeft
);

  localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_HZ - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_P     = 7'b0001100;
  localparam logic [6:0] SEG_F     = 7'b0001110;

  typedef enum logic [2:0] {
    PRESS    = 3'd0,
    EXIT_DLY = 3'd1,
    EXIT_RDY = 3'd2,
    EVAC     = 3'd3,
    DEPRESS  = 3'd4,
    REPRESS  = 3'd5,
    FAULT    = 3'd6
  } stateT;

  stateT               state;
  stateT               nxtState;
  logic [PRE_W-1:0]    prescaler;
  logic [PRE_W-1:0]    nxtPre;
  logic [PRE_W-1:0]    runPre;
  logic [TIMER_W-1:0]  nxtSecs;
  logic [TIMER_W-1:0]  runSecs;
  logic                tick;
  logic                expire;
  logic                doorsShut;
  logic                autoGo;

  // secsLeft doubles as the down-counter; it is forced to 0 whenever the next state is untimed.
  assign tick      = (prescaler == PRE_MAX);
  assign expire    = tick && (secsLeft == TIMER_W'(1));
  assign runPre    = tick ? '0 : prescaler + PRE_W'(1);
  assign runSecs   = tick ? secsLeft - TIMER_W'(1) : secsLeft;
  assign doorsShut = !innerPort && !outerPort;

`ifdef AIRLOCK_AUTO_REPRESS_EN
  logic seenOuter;

  always_ff @(posedge clock) begin
    if (!rst) begin
      seenOuter <= 1'b0;
    end else if (nxtState == DEPRESS && state != DEPRESS) begin
      seenOuter <= 1'b0;
    end else if (state == DEPRESS && outerPort) begin
      seenOuter <= 1'b1;
    end
  end

  assign autoGo = seenOuter && !leaving;
`else
  assign autoGo = 1'b0;
`endif

  always_comb begin
    nxtState = state;
    nxtPre   = '0;
    nxtSecs  = '0;
    case (state)
      PRESS: begin
        if (leaving && !outerPort) begin
          nxtState = EXIT_DLY;
          nxtSecs  = TIMER_W'(EXIT_S);
        end
      end
      EXIT_DLY: begin
        if (!leaving) begin
          nxtState = PRESS;
        end else if (expire) begin
          nxtState = EXIT_RDY;
        end else begin
          nxtPre  = runPre;
          nxtSecs = runSecs;
        end
      end
      EXIT_RDY: begin
        if (doorsShut && evac) begin
          nxtState = EVAC;
          nxtSecs  = TIMER_W'(EVAC_S);
        end else if (!leaving) begin
          nxtState = PRESS;
        end
      end
      EVAC: begin
        if (!doorsShut) begin
          nxtState = FAULT;
        end else if (expire) begin
          nxtState = DEPRESS;
        end else begin
          nxtPre  = runPre;
          nxtSecs = runSecs;
        end
      end
      DEPRESS: begin
        if (doorsShut && (pressurize || autoGo)) begin
          nxtState = REPRESS;
          nxtSecs  = TIMER_W'(PRESS_S);
        end
      end
      REPRESS: begin
        if (!doorsShut) begin
          nxtState = FAULT;
        end else if (expire) begin
          nxtState = PRESS;
        end else begin
          nxtPre  = runPre;
          nxtSecs = runSecs;
        end
      end
      FAULT: begin
        // Chamber pressure is unknown after a breach, so recovery always repressurises.
        if (faultClr && doorsShut) begin
          nxtState = REPRESS;
          nxtSecs  = TIMER_W'(PRESS_S);
        end
      end
      default: nxtState = PRESS;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      state     <= PRESS;
      prescaler <= '0;
      secsLeft  <= '0;
      canIn     <= 1'b1;
      canOut    <= 1'b0;
      display   <= SEG_BLANK;
      fault     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= nxtState;
      prescaler <= nxtPre;
      secsLeft  <= nxtSecs;
      canIn     <= (nxtState inside {PRESS, EXIT_DLY, EXIT_RDY});
      canOut    <= (nxtState == DEPRESS);
      fault     <= (nxtState == FAULT);
      busy      <= (nxtState inside {EXIT_DLY, EVAC, REPRESS});
      case (nxtState)
        EXIT_DLY: display <= SEG_L;
        EVAC:     display <= SEG_E;
        REPRESS:  display <= SEG_P;
        FAULT:    display <= SEG_F;
        default:  display <= SEG_BLANK;
      endcase
    end
  end

endmodule

// File: tb/tb_airlock_sequencer.sv
// tb/tb_airlock_sequencer.sv - directed plus randomized bench against a cycle-budget airlock model
module tb_airlock_sequencer;

  localparam int CLK_HZ  = 4;
  localparam int EXIT_S  = 5;
  localparam int EVAC_S  = 7;
  localparam int PRESS_S = 8;
  localparam int TIMER_W = 4;

`ifdef AIRLOCK_AUTO_REPRESS_EN
  localparam logic AUTO_EXP = 1'b1;
`else
  localparam logic AUTO_EXP = 1'b0;
`endif

  logic clock = 1'b0;
  logic rst = 1'b0;
  logic innerPort = 1'b0;
  logic outerPort = 1'b0;
  logic leaving = 1'b0;
  logic evac = 1'b0;
  logic pressurize = 1'b0;
  logic faultClr = 1'b0;
  logic canIn;
  logic canOut;
  logic [6:0] display;
  logic fault;
  logic busy;
  logic [TIMER_W-1:0] secsLeft;

  always #5 clock = ~clock;

  airlock_sequencer #(
    .CLK_HZ(CLK_HZ), .EXIT_S(EXIT_S), .EVAC_S(EVAC_S), .PRESS_S(PRESS_S), .TIMER_W(TIMER_W)
  ) dut (
    .clock(clock), .rst(rst), .innerPort(innerPort), .outerPort(outerPort),
    .leaving(leaving), .evac(evac), .pressurize(pressurize), .faultClr(faultClr),
    .canIn(canIn), .canOut(canOut), .display(display), .fault(fault),
    .busy(busy), .secsLeft(secsLeft)
  );

  typedef enum int {M_PRESS, M_EXIT_DLY, M_EXIT_RDY, M_EVAC, M_DEPRESS, M_REPRESS, M_FAULT} modeT;

  // Reference model: a chamber mode plus the number of clock cycles left before a timed mode ends.
  modeT mode = M_PRESS;
  int   remCycles = 0;
  bit   outerSeen = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void enterTimed(modeT m, int secs);
    mode      = m;
    remCycles = secs * CLK_HZ;
  endfunction

  function automatic void enterPlain(modeT m);
    mode      = m;
    remCycles = 0;
  endfunction

  function automatic void modelEdge();
    bit shut;
    bit autoOk;
    shut   = !innerPort && !outerPort;
    autoOk = 1'b0;
    if (!rst) begin
      enterPlain(M_PRESS);
      outerSeen = 1'b0;
      return;
    end
    case (mode)
      M_PRESS:    if (leaving && !outerPort) enterTimed(M_EXIT_DLY, EXIT_S);
      M_EXIT_DLY: begin
        if (!leaving) enterPlain(M_PRESS);
        else if (remCycles == 1) enterPlain(M_EXIT_RDY);
        else remCycles--;
      end
      M_EXIT_RDY: begin
        if (shut && evac) enterTimed(M_EVAC, EVAC_S);
        else if (!leaving) enterPlain(M_PRESS);
      end
      M_EVAC: begin
        if (!shut) enterPlain(M_FAULT);
        else if (remCycles == 1) begin
          enterPlain(M_DEPRESS);
          outerSeen = 1'b0;
        end else remCycles--;
      end
      M_DEPRESS: begin
`ifdef AIRLOCK_AUTO_REPRESS_EN
        autoOk = outerSeen && !leaving;
`endif
        if (shut && (pressurize || autoOk)) enterTimed(M_REPRESS, PRESS_S);
        else if (outerPort) outerSeen = 1'b1;
      end
      M_REPRESS: begin
        if (!shut) enterPlain(M_FAULT);
        else if (remCycles == 1) enterPlain(M_PRESS);
        else remCycles--;
      end
      M_FAULT: if (faultClr && shut) enterTimed(M_REPRESS, PRESS_S);
      default: enterPlain(M_PRESS);
    endcase
  endfunction

  function automatic logic [14:0] expOuts();
    logic ci, co, fl, bz;
    logic [6:0] seg;
    logic [3:0] sl;
    ci = (mode == M_PRESS) || (mode == M_EXIT_DLY) || (mode == M_EXIT_RDY);
    co = (mode == M_DEPRESS);
    fl = (mode == M_FAULT);
    bz = (mode == M_EXIT_DLY) || (mode == M_EVAC) || (mode == M_REPRESS);
    case (mode)
      M_EXIT_DLY: seg = 7'b1000111;
      M_EVAC:     seg = 7'b0000110;
      M_REPRESS:  seg = 7'b0001100;
      M_FAULT:    seg = 7'b0001110;
      default:    seg = 7'b1111111;
    endcase
    sl = 4'((remCycles + CLK_HZ - 1) / CLK_HZ);
    return {ci, co, seg, fl, bz, sl};
  endfunction

  task automatic step();
    @(posedge clock);
    modelEdge();
    #1;
    check("outs", {17'd0, canIn, canOut, display, fault, busy, secsLeft}, {17'd0, expOuts()});
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic toDepress();
    leaving = 1'b1;
    steps(21);
    evac = 1'b1;
    step();
    evac = 1'b0;
    steps(28);
  endtask

  initial begin
    int doorDen;

    steps(2);
    check("rstCanIn", canIn, 1);
    check("rstCanOut", canOut, 0);
    check("rstDisplay", display, 7'b1111111);
    check("rstFault", fault, 0);
    check("rstBusy", busy, 0);
    check("rstSecs", secsLeft, 0);
    rst = 1'b1;

    // Full exit cycle
    leaving = 1'b1;
    step();
    check("exitDlySecs", secsLeft, 5);
    check("exitDlyDisp", display, 7'b1000111);
    steps(20);
    check("exitRdyBusy", busy, 0);
    check("exitRdyCanIn", canIn, 1);
    evac = 1'b1;
    step();
    evac = 1'b0;
    check("evacDisp", display, 7'b0000110);
    check("evacSecs", secsLeft, 7);
    steps(28);
    check("depCanOut", canOut, 1);
    outerPort = 1'b1;
    steps(2);
    outerPort = 1'b0;
    leaving = 1'b0;
    step();
    pressurize = 1'b1;
    step();
    pressurize = 1'b0;
    check("repSecs", secsLeft, 8);
    check("repDisp", display, 7'b0001100);
    steps(32);
    check("pressCanIn", canIn, 1);
    check("pressDisp", display, 7'b1111111);

    // Cancel during exit delay
    leaving = 1'b1;
    steps(10);
    check("cancelBusyBefore", busy, 1);
    leaving = 1'b0;
    step();
    check("cancelSecs", secsLeft, 0);
    check("cancelCanIn", canIn, 1);
    check("cancelBusy", busy, 0);

    // Breach on the expiry cycle of EVAC
    leaving = 1'b1;
    steps(21);
    evac = 1'b1;
    step();
    evac = 1'b0;
    steps(27);
    check("evacLastSec", secsLeft, 1);
    innerPort = 1'b1;
    step();
    leaving = 1'b0;
    check("breachFault", fault, 1);
    check("breachDisp", display, 7'b0001110);
    faultClr = 1'b1;
    step();
    check("clrIgnored", fault, 1);
    innerPort = 1'b0;
    step();
    faultClr = 1'b0;
    check("clrSecs", secsLeft, 8);
    check("clrBusy", busy, 1);

    // Reset in the middle of REPRESS
    steps(20);
    check("midRepSecs", secsLeft, 3);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("midRstSecs", secsLeft, 0);
    check("midRstBusy", busy, 0);
    check("midRstDisp", display, 7'b1111111);
    check("midRstCanIn", canIn, 1);

    // Entry path: pressurize held while the outer door is open
    toDepress();
    leaving = 1'b0;
    pressurize = 1'b1;
    outerPort = 1'b1;
    steps(3);
    check("entryHold", canOut, 1);
    outerPort = 1'b0;
    step();
    pressurize = 1'b0;
    check("entryRepBusy", busy, 1);
    check("entryRepSecs", secsLeft, 8);
    steps(32);
    check("entryCanIn", canIn, 1);

    // Outer door cycles in DEPRESS with no pressurize command
    toDepress();
    leaving = 1'b0;
    outerPort = 1'b1;
    steps(2);
    outerPort = 1'b0;
    step();
    check("autoRepress", busy, AUTO_EXP);
    pressurize = 1'b1;
    step();
    pressurize = 1'b0;
    steps(33);

    // Randomized traffic, door activity rate varied per block
    for (int blk = 0; blk < 20; blk++) begin
      case ($urandom_range(0, 2))
        0:       doorDen = 4;
        1:       doorDen = 40;
        default: doorDen = 1000;
      endcase
      for (int i = 0; i < 150; i++) begin
        innerPort  = ($urandom_range(0, doorDen - 1) == 0);
        outerPort  = ($urandom_range(0, doorDen - 1) == 0);
        if ($urandom_range(0, 15) == 0) leaving = ~leaving;
        evac       = ($urandom_range(0, 3) == 0);
        pressurize = ($urandom_range(0, 3) == 0);
        faultClr   = ($urandom_range(0, 2) == 0);
        rst        = ($urandom_range(0, 299) != 0);
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/airlock_sequencer.md
Name: airlock_sequencer

Overview:
- Parametrised, bidirectional successor to the single-direction leaving interlock.
- Sequences the chamber through exit delay, evacuation, depressurised hold and repressurisation.
- Owns its own seconds timer (prescaler plus down-counter) instead of taking an external counter value.
- Adds door-breach fault detection with operator clear. Sits between the door switches/command buttons and the door-lock drivers/HEX display on the DE1_SoC top level.

Parameters:
CLK_HZ, 50000000, clock cycles per second tick (≥1)
EXIT_S, 5, exit-warning delay in seconds (≥1)
EVAC_S, 7, evacuation time in seconds (≥1)
PRESS_S, 8, repressurisation time in seconds (≥1)
TIMER_W, 4, width of seconds counter; must hold max(EXIT_S, EVAC_S, PRESS_S)

Ports:
clock  input  1  system clock
rst  input  1  synchronous, active-low reset (sampled on posedge clock; 0 = reset)
innerPort  input  1  1 = inner door open
outerPort  input  1  1 = outer door open
leaving  input  1  occupant requests exit (level)
evac  input  1  evacuate command (level, sampled)
pressurize  input  1  pressurise command (level, sampled)
faultClr  input  1  operator fault acknowledge
canIn  output  1  inner door unlock
canOut  output  1  outer door unlock
display  output  7  active-low 7-seg pattern
fault  output  1  breach fault flag
busy  output  1  timed state active
secsLeft  output  TIMER_W  remaining whole seconds in timed state, else 0

Behaviour:
- Moore machine. All outputs decode from the registered state and timer only; no input-to-output combinational path.
- Reset (rst=0 at a posedge):
  - state=PRESS, prescaler=0, secsLeft=0.
  - Outputs: canIn=1, canOut=0, display=7'b1111111, fault=0, busy=0.
  - Reset overrides every other input, including mid-timer and from FAULT.
- Timer:
  - Entering a timed state loads secsLeft=N and clears the prescaler.
  - Prescaler counts 0..CLK_HZ-1. At CLK_HZ-1 it wraps and secsLeft decrements.
  - Expiry is the tick where secsLeft goes 1→0. The state is left exactly N*CLK_HZ cycles after entry.
- States (canIn/canOut/display):
  - PRESS (1/0/blank): leaving & ~outerPort → EXIT_DLY (load EXIT_S).
  - EXIT_DLY (1/0/L=1000111): on expiry → EXIT_RDY. ~leaving → PRESS (cancel).
  - EXIT_RDY (1/0/blank):
    - ~innerPort & ~outerPort & evac → EVAC (load EVAC_S).
    - else ~leaving → PRESS.
  - EVAC (0/0/E=0000110): on expiry → DEPRESS. innerPort|outerPort → FAULT.
  - DEPRESS (0/1/blank):
    - Entry and exit both happen here.
    - ~innerPort & ~outerPort & pressurize → REPRESS (load PRESS_S).
  - REPRESS (0/0/P=0001100): on expiry → PRESS. innerPort|outerPort → FAULT.
  - FAULT (0/0/F=0001110, fault=1): faultClr & ~innerPort & ~outerPort → REPRESS (load PRESS_S). Chamber state is unknown, so the block always repressurises.
- busy=1 in EXIT_DLY, EVAC, REPRESS.
- secsLeft=0 in untimed states.
- Simultaneous events:
  - Door-open beats expiry in the same cycle (→ FAULT).
  - Cancel (~leaving) beats expiry in EXIT_DLY.
  - In EXIT_RDY, evac beats cancel.
  - In DEPRESS, evac and leaving are ignored.
  - In PRESS, evac and pressurize are ignored.
- Illegal state encodings go to PRESS on the next clock.

Optional Feature:
AIRLOCK_AUTO_REPRESS_EN
- Defined: DEPRESS auto-starts REPRESS when both doors are closed, leaving=0, and the outer door has been seen open at least once since entering DEPRESS (tracked by an internal flag, cleared on DEPRESS entry). The pressurize input still also starts REPRESS.
- Undefined: REPRESS starts from DEPRESS only on the pressurize command; no flag logic is present.

Test Plan:
All runs use CLK_HZ=4, EXIT_S=5, EVAC_S=7, PRESS_S=8.
1. Full exit cycle:
   - Stimulus: rst=0 then 1; leaving=1; after 20 cycles evac=1; after 28 cycles outerPort pulse 1→0, leaving=0; pressurize=1.
   - Required: states PRESS→EXIT_DLY(20 cyc)→EXIT_RDY→EVAC(28 cyc)→DEPRESS→REPRESS(32 cyc)→PRESS; canOut=1 only in DEPRESS; secsLeft counts 5..1, 7..1, 8..1.
2. Cancel:
   - Stimulus: leaving=1 for 10 cycles, then 0.
   - Required: EXIT_DLY→PRESS, canIn=1 throughout, secsLeft=0 after cancel.
3. Breach:
   - Stimulus: innerPort=1 during EVAC, including the expiry cycle.
   - Required: FAULT, fault=1, display=0001110; faultClr ignored while innerPort=1; with doors closed, faultClr gives REPRESS with secsLeft=8.
4. Entry path:
   - Stimulus: start in DEPRESS, pressurize=1 with outerPort=1.
   - Required: stays in DEPRESS; after outerPort=0, REPRESS→PRESS after 32 cycles, then canIn=1.
5. Reset mid-operation:
   - Stimulus: rst=0 for one edge during REPRESS with secsLeft=3.
   - Required: next cycle shows PRESS, secsLeft=0, busy=0, display=1111111.
6. AIRLOCK_AUTO_REPRESS_EN:
   - Stimulus: in DEPRESS, outerPort 1→0, leaving=0, pressurize=0.
   - Required: REPRESS entered the cycle after the doors close. Without the macro, the block stays in DEPRESS.
